// File: rtl/vga_scaled_display.sv
// VGA display: programmable timing, integer upscale, double-buffered
// framebuffer reads (1-clk latency) and a per-frame colour mode.
//
// Ports:
//   clk, rstn           clock, async active-low reset
//   mode[1:0]           colour mode (0 normal, 1 grey, 2 invert, 3 blank)
//   swap_req / swap_ack bank swap request level / one-clk ack pulse
//   bank                bank being displayed (writer owns ~bank)
//   vblank_start        one-clk pulse at start of vertical blank
//   fb_raddr / fb_rdata framebuffer read address / data one clk later
//   rgb, hs, vs         pixel output and active-high syncs (aligned)
//
// Build option: define VGA_TEST_PATTERN_EN to turn mode 3 into
// eight full-scale vertical colour bars across the active width.

module vga_scaled_display #(
  parameter int DW       = 12,
  parameter int AW       = 16,
  parameter int H_LEN    = 200,
  parameter int V_LEN    = 150,
  parameter int SCALE    = 4,
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    mode,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          bank,
  output logic          vblank_start,
  output logic [AW-1:0] fb_raddr,
  input  logic [DW-1:0] fb_rdata,
  output logic [DW-1:0] rgb,
  output logic          hs,
  output logic          vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL + 1);
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int DVW = $clog2(CLK_DIV);
  localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW  = DW / 3;
  localparam int IMG_W = (H_ACTIVE < H_LEN * SCALE) ? H_ACTIVE : H_LEN * SCALE;
  localparam int IMG_H = (V_ACTIVE < V_LEN * SCALE) ? V_ACTIVE : V_LEN * SCALE;

  localparam logic [DVW-1:0] DIV_MAX = DVW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_MAX   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_MAX   = VW'(V_TOTAL - 1);
  localparam logic [SW-1:0]  S_MAX   = SW'(SCALE - 1);
  localparam logic [AW-1:0]  BANK_SZ = AW'(H_LEN * V_LEN);
  localparam logic [AW-1:0]  ROW_SZ  = AW'(H_LEN);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_scaled_display: CLK_DIV must be >= 2");
  end

  typedef enum logic [1:0] {
    M_NORM  = 2'd0,
    M_GREY  = 2'd1,
    M_INV   = 2'd2,
    M_BLANK = 2'd3
  } mode_e;

  logic [DVW-1:0] div_q, div_d;
  logic           pe;

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [SW-1:0]  hsub_q, hsub_d;
  logic [SW-1:0]  vsub_q, vsub_d;
  logic [AW-1:0]  hx_q, hx_d;
  logic [AW-1:0]  row_q, row_d;

  mode_e          mode_q;
  logic           bank_q;
  logic           ack_q;
  logic           vbs_q;
  logic           vb;

  logic [AW-1:0]  raddr_q, raddr_d;
  logic           img1_q, img1_d;
  logic           act1_q, act1_d;
  logic           hs1_q, hs1_d;
  logic           vs1_q, vs1_d;

  logic [DW-1:0]  rgb_q, rgb_d;
  logic           hs_q;
  logic           vs_q;

  logic [CW-1:0]  r_c, g_c, b_c, y_c;
  logic [CW+1:0]  sum_c;
  logic [DW-1:0]  pix_c;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar1_q, bar1_d;

  function automatic logic [DW-1:0] bar_colour(input logic [2:0] idx);
    logic [2:0] c;
    unique case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return DW'({{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}});
  endfunction

  // Bar index by threshold compares; avoids a divider on hcnt.
  always_comb begin
    bar1_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= HW'(k * BAR_W)) bar1_d = 3'(k);
    end
  end
`endif

  assign pe = (div_q == '0);
  assign div_d = (div_q == DIV_MAX) ? '0 : div_q + DVW'(1);

  assign vb = pe && (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE));

  // Raster counters plus scaled source position. Sub-counters only
  // run inside the image so hx/row_base stay within one bank.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hsub_d = hsub_q;
    vsub_d = vsub_q;
    hx_d   = hx_q;
    row_d  = row_q;
    if (pe) begin
      if (hcnt_q == H_MAX) begin
        hcnt_d = '0;
        hsub_d = '0;
        hx_d   = '0;
        if (vcnt_q == V_MAX) begin
          vcnt_d = '0;
          vsub_d = '0;
          row_d  = '0;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
          if (vcnt_q < VW'(IMG_H - 1)) begin
            if (vsub_q == S_MAX) begin
              vsub_d = '0;
              row_d  = row_q + ROW_SZ;
            end else begin
              vsub_d = vsub_q + SW'(1);
            end
          end
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
        if (hcnt_q < HW'(IMG_W - 1)) begin
          if (hsub_q == S_MAX) begin
            hsub_d = '0;
            hx_d   = hx_q + AW'(1);
          end else begin
            hsub_d = hsub_q + SW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    raddr_d = (bank_q ? BANK_SZ : '0) + row_q + hx_q;
    img1_d  = (hcnt_q < HW'(IMG_W)) && (vcnt_q < VW'(IMG_H));
    act1_d  = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    hs1_d   = (hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
              (hcnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    vs1_d   = (vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
              (vcnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
  end

  always_comb begin
    r_c   = fb_rdata[3*CW-1 -: CW];
    g_c   = fb_rdata[2*CW-1 -: CW];
    b_c   = fb_rdata[CW-1:0];
    sum_c = {2'b00, r_c} + {1'b0, g_c, 1'b0} + {2'b00, b_c};
    y_c   = sum_c[CW+1:2];
    pix_c = '0;
    unique case (mode_q)
      M_NORM:  pix_c = fb_rdata;
      M_GREY:  pix_c = DW'({y_c, y_c, y_c});
      M_INV:   pix_c = ~fb_rdata;
      M_BLANK: pix_c = '0;
      default: pix_c = '0;
    endcase
    rgb_d = (act1_q && img1_q) ? pix_c : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (mode_q == M_BLANK) begin
      rgb_d = act1_q ? bar_colour(bar1_q) : '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsub_q  <= '0;
      vsub_q  <= '0;
      hx_q    <= '0;
      row_q   <= '0;
      mode_q  <= M_NORM;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
      vbs_q   <= 1'b0;
      raddr_q <= '0;
      img1_q  <= 1'b0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      bar1_q  <= '0;
`endif
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      hx_q   <= hx_d;
      row_q  <= row_d;
      vbs_q  <= vb;
      ack_q  <= vb && swap_req;
      if (vb) begin
        mode_q <= mode_e'(mode);
        if (swap_req) bank_q <= ~bank_q;
      end
      if (pe) begin
        raddr_q <= raddr_d;
        img1_q  <= img1_d;
        act1_q  <= act1_d;
        hs1_q   <= hs1_d;
        vs1_q   <= vs1_d;
        rgb_q   <= rgb_d;
        hs_q    <= hs1_q;
        vs_q    <= vs1_q;
`ifdef VGA_TEST_PATTERN_EN
        bar1_q  <= bar1_d;
`endif
      end
    end
  end

  assign swap_ack     = ack_q;
  assign bank         = bank_q;
  assign vblank_start = vbs_q;
  assign fb_raddr     = raddr_q;
  assign rgb          = rgb_q;
  assign hs           = hs_q;
  assign vs           = vs_q;

endmodule

// File: tb/tb_vga_scaled_display.sv
// Bench for vga_scaled_display with a reduced raster; expected outputs
// come from raster position arithmetic and a colour-rule model.

module tb_vga_scaled_display;

  localparam int DW  = 12;
  localparam int AW  = 8;
  localparam int HL  = 8;
  localparam int VL  = 6;
  localparam int SC  = 2;
  localparam int CD  = 2;
  localparam int HA  = 20;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 14;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int IW  = (HA < HL * SC) ? HA : HL * SC;
  localparam int IH  = (VA < VL * SC) ? VA : VL * SC;

  logic          clk;
  logic          rstn;
  logic [1:0]    mode;
  logic          swap_req;
  logic          swap_ack;
  logic          bank;
  logic          vblank_start;
  logic [AW-1:0] fb_raddr;
  logic [DW-1:0] fb_rdata;
  logic [DW-1:0] rgb;
  logic          hs;
  logic          vs;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int   checks;
  int   fails;
  int   pos;
  logic m_bank;
  logic bank_prev;
  logic [1:0] m_mode;

  vga_scaled_display #(
    .DW(DW), .AW(AW), .H_LEN(HL), .V_LEN(VL), .SCALE(SC),
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .mode(mode),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .bank(bank),
    .vblank_start(vblank_start),
    .fb_raddr(fb_raddr),
    .fb_rdata(fb_rdata),
    .rgb(rgb),
    .hs(hs),
    .vs(vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) fb_rdata <= mem[fb_raddr];

  function automatic int hpos(input int p);
    return p % HT;
  endfunction

  function automatic int vpos(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic logic in_img(input int p);
    return (hpos(p) < IW) && (vpos(p) < IH);
  endfunction

  function automatic int addr_of(input int p, input logic bk);
    return (bk ? HL * VL : 0) + (vpos(p) / SC) * HL + hpos(p) / SC;
  endfunction

  function automatic logic [11:0] colour(input logic [1:0] md,
                                         input logic [11:0] p);
    int r, g, b, y;
    logic [3:0] y4;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    y = (r + 2 * g + b) / 4;
    y4 = y[3:0];
    case (md)
      2'd0:    return p;
      2'd1:    return {y4, y4, y4};
      2'd2:    return ~p;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] exp_pix(input int p, input logic bk,
                                          input logic [1:0] md);
    if (!in_img(p)) return 12'h000;
    return colour(md, mem[addr_of(p, bk)]);
  endfunction

  function automatic logic hsync(input int p);
    return (hpos(p) >= HA + HFP) && (hpos(p) < HA + HFP + HSY);
  endfunction

  function automatic logic vsync(input int p);
    return (vpos(p) >= VA + VFP) && (vpos(p) < VA + VFP + VSY);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hs", 32'(hs), 0);
    chk("rst_vs", 32'(vs), 0);
    chk("rst_bank", 32'(bank), 0);
    chk("rst_ack", 32'(swap_ack), 0);
    chk("rst_vbs", 32'(vblank_start), 0);
    chk("rst_addr", 32'(fb_raddr), 0);
  endtask

  task automatic model_reset();
    pos       = 0;
    m_bank    = 1'b0;
    bank_prev = 1'b0;
    m_mode    = 2'd0;
  endtask

  // One pixel-enable period. Edge m processes raster position pos;
  // rgb/hs/vs then show position pos-1 and fb_raddr shows pos.
  task automatic pe_step();
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, e_vb, e_ack, fbk;
    int          e_addr, q;
    q     = pos;
    e_rgb = (q >= 1) ? exp_pix(q - 1, bank_prev, m_mode) : 12'h000;
    e_hs  = (q >= 1) && hsync(q - 1);
    e_vs  = (q >= 1) && vsync(q - 1);
    fbk   = m_bank;
    e_vb  = (hpos(q) == 0) && (vpos(q) == VA);
    e_ack = e_vb && swap_req;
    if (e_vb) begin
      m_mode = mode;
      if (swap_req) m_bank = ~m_bank;
    end
    e_addr = addr_of(q, fbk);
    @(posedge clk);
    #1;
    chk("rgb", 32'(rgb), 32'(e_rgb));
    chk("hs", 32'(hs), 32'(e_hs));
    chk("vs", 32'(vs), 32'(e_vs));
    chk("vblank_start", 32'(vblank_start), 32'(e_vb));
    chk("swap_ack", 32'(swap_ack), 32'(e_ack));
    chk("bank", 32'(bank), 32'(m_bank));
    if (in_img(q)) chk("fb_raddr", 32'(fb_raddr), 32'(e_addr));
    bank_prev = fbk;
    pos++;
    if (e_ack) swap_req = 1'b0;
    for (int i = 1; i < CD; i++) begin
      @(posedge clk);
      #1;
      chk("vbs_width", 32'(vblank_start), 0);
      chk("ack_width", 32'(swap_ack), 0);
    end
  endtask

  task automatic run_pe(input int n);
    for (int i = 0; i < n; i++) pe_step();
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rstn     = 1'b0;
    mode     = 2'd0;
    swap_req = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    mem[0] = 12'hF80;
    mem[1] = 12'h0F0;
    model_reset();

    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero();
    end
    rstn = 1'b1;

    // Mode changes mid-frame only take effect after the next vblank.
    run_pe(200);
    mode = 2'd1;
    run_pe(532);
    mode = 2'd2;
    run_pe(300);
    mode = 2'd0;
    swap_req = 1'b1;
    run_pe(600);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if (!swap_req && $urandom_range(0, 399) == 0) swap_req = 1'b1;
      pe_step();
    end

    // Asynchronous reset in the middle of a line.
    rstn = 1'b0;
    #1;
    chk_zero();
    swap_req = 1'b0;
    mode = 2'($urandom_range(0, 3));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero();
    end
    model_reset();
    rstn = 1'b1;
    run_pe(700);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
